iter_alu: RTL and testbench

Parametrised multi-cycle ALU that generalises the lab's two-operation combinational adder/shifter. It adds width parameters, subtract and multiply operations, a status flag, and an iterative datapath for shift and multiply. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake, so the block can sit between a switch/register front end and a display or accumulator stage that may stall.

---
 rtl/iter_alu.sv | 107 ++++++++++
 tb/tb_iter_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle ALU: ADD/SUB complete at accept, SHL and MUL iterate one step
// per cycle. Operands and results move through valid/ready handshakes.
module iter_alu #(
  parameter int W    = 4,
  parameter int OUTW = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUTW-1:0] result,
  output logic            flag,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_SHL, OP_MUL} op_e;

  state_e          r_state;
  op_e             r_op;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    r_mplier;
  logic [OUTW-1:0] r_mcand;
  logic [OUTW-1:0] r_result;
  logic            r_flag;

  logic [OUTW-1:0] w_a;
  logic [OUTW-1:0] w_b;

  assign w_a = OUTW'(a);
  assign w_b = OUTW'(b);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign flag      = r_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= op_e'(op);
            r_flag   <= 1'b0;
            r_mcand  <= w_a;
            r_mplier <= b;
            case (op_e'(op))
              OP_ADD: begin
                r_result <= w_a + w_b;
                r_cnt    <= '0;
                r_state  <= S_DONE;
              end
              OP_SUB: begin
                r_result <= w_a - w_b;
                r_flag   <= (a < b);
                r_cnt    <= '0;
                r_state  <= S_DONE;
              end
              OP_SHL: begin
                r_result <= w_a;
                r_cnt    <= b;
                r_state  <= (b == '0) ? S_DONE : S_BUSY;
              end
              OP_MUL: begin
                r_result <= '0;
                r_cnt    <= W'(W);
                r_state  <= S_BUSY;
              end
            endcase
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - W'(1);
          if (r_op == OP_SHL) begin
            // Sticky overflow: any 1 leaving the top bit sets the flag.
            r_flag   <= r_flag | r_result[OUTW-1];
            r_result <= r_result << 1;
          end else begin
            if (r_mplier[0]) r_result <= r_result + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
          if (r_cnt == W'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: scoreboard of expected {flag,result} pushed at
// stimulus, popped when out_valid appears; second instance covers OUTW=8.
module tb_iter_alu;
  localparam int W    = 4;
  localparam int OUTW = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic [1:0]      op = '0;
  logic            in_ready, out_valid, flag, busy;
  logic [OUTW-1:0] result;

  logic       v8 = 1'b0;
  logic       or8 = 1'b1;
  logic [3:0] a8 = '0;
  logic [3:0] b8 = '0;
  logic [1:0] op8 = '0;
  logic       ir8, ov8, f8, busy8;
  logic [7:0] res8;

  int total = 0;
  int bad   = 0;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  iter_alu #(.W(W), .OUTW(OUTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .busy(busy)
  );

  iter_alu #(.W(4), .OUTW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .flag(f8), .busy(busy8)
  );

  function automatic logic [20:0] model(input int outw, input logic [3:0] ma,
                                        input logic [3:0] mb, input logic [1:0] mop);
    longint v;
    logic   f;
    longint mask;
    mask = (longint'(1) << outw) - 1;
    f = 1'b0;
    case (mop)
      2'd0: v = longint'(ma) + longint'(mb);
      2'd1: begin v = longint'(ma) - longint'(mb); f = (ma < mb); end
      2'd2: begin v = longint'(ma) << mb; f = ((v >> outw) != 0); end
      default: v = longint'(ma) * longint'(mb);
    endcase
    v = v & mask;
    return {f, v[19:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic [1:0] top, input int lat);
    logic [20:0] e;
    int n;
    sb.push_back(model(OUTW, ta, tb_, top));
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ":in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0; a = ~ta; b = ~tb_; op = ~top;
    n = 1;
    while (!out_valid && n < 100) begin
      check({tag, ":busy"}, busy, 1);
      check({tag, ":in_ready_low"}, in_ready, 0);
      tick();
      n++;
    end
    check({tag, ":latency"}, n, lat);
    e = sb.pop_front();
    check({tag, ":result"}, result, e[19:0]);
    check({tag, ":flag"}, flag, e[20]);
    check({tag, ":busy_done"}, busy, 1);
    tick();
    check({tag, ":out_valid_after"}, out_valid, 0);
    check({tag, ":in_ready_after"}, in_ready, 1);
    check({tag, ":result_held"}, result, e[19:0]);
  endtask

  initial begin
    logic [20:0] e;
    logic [3:0]  ra, rb;
    logic [1:0]  ro;
    int          lat, n;

    #2;
    check("rst:in_ready", in_ready, 1);
    check("rst:out_valid", out_valid, 0);
    check("rst:busy", busy, 0);
    check("rst:result", result, 0);
    check("rst:flag", flag, 0);
    check("rst8:in_ready", ir8, 1);
    #5 rst_n = 1'b1;
    tick();

    run_op("add", 4'd9, 4'd7, 2'b00, 1);
    run_op("sub_borrow", 4'd3, 4'd5, 2'b01, 1);
    run_op("sub", 4'd5, 4'd3, 2'b01, 1);
    run_op("shl15", 4'hF, 4'd15, 2'b10, 16);
    run_op("shl0", 4'hF, 4'd0, 2'b10, 1);
    run_op("mul", 4'd15, 4'd15, 2'b11, 5);
    run_op("mul2", 4'd6, 4'd11, 2'b11, 5);
    run_op("sub_zero", 4'd0, 4'd15, 2'b01, 1);

    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      lat = (ro == 2'b10) ? 1 + int'(rb) : (ro == 2'b11) ? 1 + W : 1;
      run_op("rnd", ra, rb, ro, lat);
    end

    // SHL overflow on the narrow instance
    e = model(8, 4'hF, 4'd6, 2'b10);
    a8 = 4'hF; b8 = 4'd6; op8 = 2'b10; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    n = 1;
    while (!ov8 && n < 100) begin tick(); n++; end
    check("shl8:latency", n, 7);
    check("shl8:result", res8, e[7:0]);
    check("shl8:flag", f8, e[20]);
    tick();
    check("shl8:in_ready_after", ir8, 1);

    // Backpressure with a new op waiting on in_valid
    sb.push_back(model(OUTW, 4'd2, 4'd3, 2'b00));
    sb.push_back(model(OUTW, 4'd4, 4'd1, 2'b01));
    a = 4'd2; b = 4'd3; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 4'd4; b = 4'd1; op = 2'b01;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      check("bp:out_valid", out_valid, 1);
      check("bp:result", result, e[19:0]);
      check("bp:in_ready", in_ready, 0);
      tick();
    end
    check("bp:still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp:idle_valid", out_valid, 0);
    check("bp:idle_ready", in_ready, 1);
    check("bp:idle_result", result, e[19:0]);
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    check("bp2:out_valid", out_valid, 1);
    check("bp2:result", result, e[19:0]);
    check("bp2:flag", flag, e[20]);
    tick();
    check("bp2:in_ready_after", in_ready, 1);

    // Asynchronous reset in the middle of a multiply
    a = 4'd15; b = 4'd15; op = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rstmid:busy_before", busy, 1);
    check("rstmid:partial", result, 20'd45);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid:result", result, 0);
    check("rstmid:out_valid", out_valid, 0);
    check("rstmid:flag", flag, 0);
    check("rstmid:busy", busy, 0);
    check("rstmid:in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    tick();
    run_op("add_after_rst", 4'd1, 4'd1, 2'b00, 1);

    check("sb:empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
